// File: rtl/fc_topk_collector_if.sv
// FC logit beat stream: one beat per class, no backpressure.
//   valid     - beat strobe
//   class_idx - class index of the beat
//   logit     - signed int8 logit
// master drives the stream (accelerator / bench), slave consumes it (collector).
interface fc_topk_collector_if #(
  parameter int unsigned IDX_W = 11
) ();
  logic                    valid;
  logic [IDX_W-1:0]        class_idx;
  logic signed [7:0]       logit;

  modport master (output valid, output class_idx, output logit);
  modport slave  (input  valid, input  class_idx, input  logit);
endinterface

// File: rtl/fc_topk_collector.sv
// Top-K collector for the FC logit stream.
// Keeps a sorted table of the best TOP_K (class index, logit) pairs with single-cycle insertion
// and closes a frame after NUM_CLASSES accepted beats or on flush.
// Ports:
//   CLK, RESETn     - clock, asynchronous active-low reset
//   start           - opens a new frame, clears table, counts and errors
//   flush           - closes the current frame early
//   fc_in           - beat stream (slave side)
//   busy            - high while collecting
//   result_valid    - one-cycle pulse when the result is final
//   result_partial  - frame closed with fewer than NUM_CLASSES beats
//   top_idx/logit   - packed table, entry 0 at LSBs is best; invalid entries read as 0
//   top_count       - number of valid entries
//   beat_count      - beats accepted in the current or last frame
//   err_idx         - out-of-range class index seen this frame
//   err_stray       - beat seen outside collection since last start
module fc_topk_collector #(
  parameter int unsigned NUM_CLASSES = 1000,
  parameter int unsigned TOP_K       = 5,
  parameter int unsigned IDX_W       = 11
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   start,
  input  logic                   flush,
  fc_topk_collector_if.slave     fc_in,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_partial,
  output logic [TOP_K*IDX_W-1:0] top_idx,
  output logic [TOP_K*8-1:0]     top_logit,
  output logic [3:0]             top_count,
  output logic [IDX_W-1:0]       beat_count,
  output logic                   err_idx,
  output logic                   err_stray
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  localparam logic [IDX_W-1:0] NumCls  = IDX_W'(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LastCnt = IDX_W'(NUM_CLASSES - 1);
  localparam logic [3:0]       TopKCnt = 4'(TOP_K);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        tbl_idx_q   [TOP_K];
  logic [IDX_W-1:0]        tbl_idx_d   [TOP_K];
  logic signed [7:0]       tbl_logit_q [TOP_K];
  logic signed [7:0]       tbl_logit_d [TOP_K];
  logic [TOP_K-1:0]        tbl_vld_q, tbl_vld_d;
  logic [IDX_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]              top_cnt_q, top_cnt_d;
  logic                    err_idx_q, err_idx_d;
  logic                    err_stray_q, err_stray_d;
  logic                    partial_q, partial_d;
  logic                    rv_q, rv_d;

  logic                    in_collect;
  logic                    in_range;
  logic                    accept;
  logic                    last_beat;
  logic                    close;
  logic [TOP_K-1:0]        beats;

  always_comb begin
    in_collect = (state_q == StCollect);
    in_range   = (fc_in.class_idx < NumCls);
    // A start in the same cycle discards any in-flight beat.
    accept     = in_collect && fc_in.valid && in_range && !start;
    last_beat  = accept && (beat_cnt_q == LastCnt);
    close      = in_collect && !start && (last_beat || flush);
  end

  // The table is kept sorted with valid entries first, so beats[] is a thermometer code:
  // once the new beat beats entry i it also beats every entry below it.
  always_comb begin
    for (int i = 0; i < TOP_K; i++) begin
      beats[i] = !tbl_vld_q[i] ||
                 (fc_in.logit > tbl_logit_q[i]) ||
                 ((fc_in.logit == tbl_logit_q[i]) && (fc_in.class_idx < tbl_idx_q[i]));
    end
  end

  always_comb begin
    tbl_idx_d   = tbl_idx_q;
    tbl_logit_d = tbl_logit_q;
    tbl_vld_d   = tbl_vld_q;
    if (start) begin
      for (int i = 0; i < TOP_K; i++) begin
        tbl_idx_d[i]   = '1;
        tbl_logit_d[i] = -8'sd128;
      end
      tbl_vld_d = '0;
    end else if (accept) begin
      if (beats[0]) begin
        tbl_idx_d[0]   = fc_in.class_idx;
        tbl_logit_d[0] = fc_in.logit;
        tbl_vld_d[0]   = 1'b1;
      end
      for (int i = 1; i < TOP_K; i++) begin
        if (beats[i-1]) begin
          tbl_idx_d[i]   = tbl_idx_q[i-1];
          tbl_logit_d[i] = tbl_logit_q[i-1];
          tbl_vld_d[i]   = tbl_vld_q[i-1];
        end else if (beats[i]) begin
          tbl_idx_d[i]   = fc_in.class_idx;
          tbl_logit_d[i] = fc_in.logit;
          tbl_vld_d[i]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    top_cnt_d   = top_cnt_q;
    err_idx_d   = err_idx_q;
    err_stray_d = err_stray_q;
    partial_d   = partial_q;
    rv_d        = close;
    if (start) begin
      state_d     = StCollect;
      beat_cnt_d  = '0;
      top_cnt_d   = '0;
      err_idx_d   = 1'b0;
      err_stray_d = 1'b0;
      partial_d   = 1'b0;
    end else begin
      if (accept && (beat_cnt_q != NumCls)) beat_cnt_d = beat_cnt_q + 1'b1;
      if (accept && (top_cnt_q != TopKCnt)) top_cnt_d = top_cnt_q + 4'd1;
      if (in_collect && fc_in.valid && !in_range) err_idx_d = 1'b1;
      if (!in_collect && fc_in.valid) err_stray_d = 1'b1;
      if (close) begin
        state_d   = StDone;
        partial_d = (beat_cnt_d < NumCls);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= StIdle;
      for (int i = 0; i < TOP_K; i++) begin
        tbl_idx_q[i]   <= '1;
        tbl_logit_q[i] <= -8'sd128;
      end
      tbl_vld_q   <= '0;
      beat_cnt_q  <= '0;
      top_cnt_q   <= '0;
      err_idx_q   <= 1'b0;
      err_stray_q <= 1'b0;
      partial_q   <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_idx_q   <= tbl_idx_d;
      tbl_logit_q <= tbl_logit_d;
      tbl_vld_q   <= tbl_vld_d;
      beat_cnt_q  <= beat_cnt_d;
      top_cnt_q   <= top_cnt_d;
      err_idx_q   <= err_idx_d;
      err_stray_q <= err_stray_d;
      partial_q   <= partial_d;
      rv_q        <= rv_d;
    end
  end

  // Invalid entries read as zero so the outputs are all-zero out of reset.
  always_comb begin
    for (int i = 0; i < TOP_K; i++) begin
      top_idx[i*IDX_W +: IDX_W] = tbl_vld_q[i] ? tbl_idx_q[i] : '0;
      top_logit[i*8 +: 8]       = tbl_vld_q[i] ? tbl_logit_q[i] : 8'h00;
    end
  end

  assign busy           = in_collect;
  assign result_valid   = rv_q;
  assign result_partial = partial_q;
  assign top_count      = top_cnt_q;
  assign beat_count     = beat_cnt_q;
  assign err_idx        = err_idx_q;
  assign err_stray      = err_stray_q;

endmodule
